q_6_7_str: RTL and testbench



---
 rtl/q_6_7_str.sv | 70 +++++++
 tb/tb_q_6_7_str.sv | 117 +++++++++++
 2 files changed

// File: rtl/q_6_7_str.sv
// 4-bit universal shift register: hold, rotate right, rotate left, parallel load.
// Built from one D flip-flop and one 4:1 mux per bit, with a synchronous clear on the D inputs.

module q_6_7_str_mux4 (
    input  logic       i_d0,
    input  logic       i_d1,
    input  logic       i_d2,
    input  logic       i_d3,
    input  logic [1:0] i_sel,
    output logic       o_y
);
    always_comb begin
        o_y = i_d0;
        case (i_sel)
            2'b00:   o_y = i_d0;
            2'b01:   o_y = i_d1;
            2'b10:   o_y = i_d2;
            2'b11:   o_y = i_d3;
            default: o_y = i_d0;
        endcase
    end
endmodule

module q_6_7_str_dff (
    input  logic clk,
    input  logic i_d,
    output logic o_q
);
    logic r_q;

    always_ff @(posedge clk) begin
        r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

module q_6_7_str (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic [3:0] I,
    output logic [3:0] A
);
    logic [3:0] w_mux;
    logic [3:0] w_d;

    // Reset takes priority over every mode: it forces each D input low before the edge.
    assign w_d = w_mux & {4{~rst}};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            // Input 1 takes the bit to the left (rotate right); input 2 the bit to the right.
            q_6_7_str_mux4 u_mux (
                .i_d0  (A[gi]),
                .i_d1  (A[(gi + 1) % 4]),
                .i_d2  (A[(gi + 3) % 4]),
                .i_d3  (I[gi]),
                .i_sel (sel),
                .o_y   (w_mux[gi])
            );

            q_6_7_str_dff u_dff (
                .clk (clk),
                .i_d (w_d[gi]),
                .o_q (A[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_q_6_7_str.sv
// Scoreboard bench for q_6_7_str: directed vectors push expected A values,
// an independent monitor pops and compares one value after every clock edge.

module tb_q_6_7_str;
    logic       clk;
    logic       rst;
    logic [1:0] sel;
    logic [3:0] I;
    logic [3:0] A;

    typedef struct {
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   stim_done = 0;

    q_6_7_str dut (
        .clk (clk),
        .rst (rst),
        .sel (sel),
        .I   (I),
        .A   (A)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the expected result applies to the next rising edge.
    task automatic issue(input logic r, input logic [1:0] s, input logic [3:0] d,
                         input logic [3:0] e, input string name);
        exp_t item;
        @(negedge clk);
        rst = r;
        sel = s;
        I   = d;
        item.exp  = e;
        item.name = name;
        exp_q.push_back(item);
    endtask

    // Monitor: one transaction per rising edge while expectations are pending.
    initial begin
        exp_t item;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                n_tests++;
                if (A !== item.exp) begin
                    n_fail++;
                    $display("FAIL %s: A=%b expected %b", item.name, A, item.exp);
                end else begin
                    $display("ok   %s: A=%b", item.name, A);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        sel = 2'b11;
        I   = 4'b1111;

        issue(1, 2'b11, 4'b1111, 4'b0000, "reset_over_load");
        issue(0, 2'b11, 4'b1010, 4'b1010, "load_1010");
        issue(0, 2'b00, 4'b0011, 4'b1010, "hold_1");
        issue(0, 2'b00, 4'b0011, 4'b1010, "hold_2");
        issue(0, 2'b00, 4'b0011, 4'b1010, "hold_3");
        issue(0, 2'b01, 4'b0000, 4'b0101, "rr_1010");
        issue(0, 2'b01, 4'b0000, 4'b1010, "rr_0101");

        issue(0, 2'b11, 4'b0011, 4'b0011, "load_0011_a");
        issue(0, 2'b01, 4'b1111, 4'b1001, "rr_step1");
        issue(0, 2'b01, 4'b1111, 4'b1100, "rr_step2");
        issue(0, 2'b01, 4'b1111, 4'b0110, "rr_step3");
        issue(0, 2'b01, 4'b1111, 4'b0011, "rr_step4");

        issue(0, 2'b11, 4'b0011, 4'b0011, "load_0011_b");
        issue(0, 2'b10, 4'b0000, 4'b0110, "rl_step1");
        issue(0, 2'b10, 4'b0000, 4'b1100, "rl_step2");
        issue(0, 2'b10, 4'b0000, 4'b1001, "rl_step3");
        issue(0, 2'b10, 4'b0000, 4'b0011, "rl_step4");

        issue(0, 2'b11, 4'b1001, 4'b1001, "load_1001");
        issue(0, 2'b01, 4'b0000, 4'b1100, "rr_to_1100");
        issue(1, 2'b01, 4'b1111, 4'b0000, "mid_reset");
        issue(0, 2'b01, 4'b1111, 4'b0000, "rr_zero");
        issue(0, 2'b10, 4'b1111, 4'b0000, "rl_zero");

        issue(0, 2'b11, 4'b1111, 4'b1111, "load_1111");
        issue(0, 2'b01, 4'b1100, 4'b1111, "rr_1111");
        issue(0, 2'b10, 4'b1100, 4'b1111, "rl_1111");
        issue(0, 2'b11, 4'b1100, 4'b1100, "load_1100");
        issue(0, 2'b10, 4'b0000, 4'b1001, "rl_1100");

        issue(0, 2'b11, 4'b0101, 4'b0101, "load_0101");
        issue(0, 2'b10, 4'b0000, 4'b1010, "rl_0101");
        issue(0, 2'b10, 4'b0000, 4'b0101, "rl_1010");
        issue(0, 2'b00, 4'b1111, 4'b0101, "hold_0101");

        stim_done = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
